// File: rtl/instr_encoder_loader_if.sv
// Field-stream and instruction-memory write bus for instr_encoder_loader.
// slave = loader side; master = host/memory side.
`timescale 1ns/1ps
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport slave (
        input  in_valid, in_last, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );

    modport master (
        output in_valid, in_last, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I fields (I, I_LD, S, SB) into instruction words and streams
// the range-checked words into instruction memory at sequential addresses.
`timescale 1ns/1ps
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    instr_encoder_loader_if.slave bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_full,
    output logic                o_err,
    output logic [7:0]          o_err_count,
    output logic [ADDR_W:0]     o_word_count
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_we, r_last_seen, r_done, r_full, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [7:0]        r_err_count;
    logic [ADDR_W:0]   r_wc;

    logic              w_in_ready, w_accept, w_wr_done, w_start, w_legal;
    logic [ADDR_W:0]   w_wc_nxt;
    logic [31:0]       w_enc;
    logic [6:0]        w_opcode;
    logic signed [31:0] w_imm;

    assign w_wr_done = r_we && bus.mem_ready;
    assign w_wc_nxt  = r_wc + {{ADDR_W{1'b0}}, w_wr_done};
    assign w_start   = i_start && (r_state != S_LOAD);
    // The pending word counts against DEPTH so the session never over-commits.
    assign w_in_ready = (r_state == S_LOAD) && !r_last_seen
                     && ((32'(r_wc) + 32'(r_we)) < DEPTH)
                     && (!r_we || bus.mem_ready);
    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_imm     = $signed(bus.in_imm);

    always_comb begin
        w_legal  = 1'b0;
        w_opcode = 7'b0010011;
        w_enc    = 32'd0;
        case (bus.in_fmt)
            2'b00: w_opcode = 7'b0010011;
            2'b01: w_opcode = 7'b0000011;
            2'b10: w_opcode = 7'b0100011;
            default: w_opcode = 7'b1100011;
        endcase
        if (bus.in_fmt == 2'b11)
            w_legal = (w_imm >= -4096) && (w_imm <= 4094) && !bus.in_imm[0];
        else
            w_legal = (w_imm >= -2048) && (w_imm <= 2047);
        case (bus.in_fmt)
            2'b10: w_enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_imm[4:0], w_opcode};
            2'b11: w_enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], w_opcode};
            default: w_enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, w_opcode};
        endcase
    end

    // Completion counts the write retiring on this very edge, so DONE is not delayed a cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_LOAD;
            S_LOAD: if ((r_last_seen && (!r_we || bus.mem_ready)) || (32'(w_wc_nxt) == DEPTH))
                        w_state_nxt = S_DONE;
            S_DONE: if (i_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_last_seen <= 1'b0;
            r_done      <= 1'b0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
            r_wc        <= '0;
            r_addr      <= ADDR_W'(BASE_ADDR);
            r_wdata     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_LOAD) && (w_state_nxt == S_DONE);
            if (w_start) begin
                r_we        <= 1'b0;
                r_last_seen <= 1'b0;
                r_full      <= 1'b0;
                r_err       <= 1'b0;
                r_err_count <= 8'd0;
                r_wc        <= '0;
                r_addr      <= ADDR_W'(BASE_ADDR);
            end else if (r_state == S_LOAD) begin
                r_wc <= w_wc_nxt;
                if (32'(w_wc_nxt) == DEPTH) r_full <= 1'b1;
                if (w_accept) begin
                    if (bus.in_last) r_last_seen <= 1'b1;
                    if (w_legal) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_enc;
                        r_addr  <= ADDR_W'(BASE_ADDR) + w_wc_nxt[ADDR_W-1:0];
                    end else begin
                        // Accept implies any pending write retires on this edge.
                        r_we  <= 1'b0;
                        r_err <= 1'b1;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                    end
                end else if (w_wr_done) begin
                    r_we <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_busy        = (r_state == S_LOAD);
    assign o_done        = r_done;
    assign o_full        = r_full;
    assign o_err         = r_err;
    assign o_err_count   = r_err_count;
    assign o_word_count  = r_wc;
endmodule
